// File: rtl/pipe_core.sv
// Three-stage fetch/decode/execute core: 16-bit instructions, 8 x DATA_W registers, X->D bypass.
// Execute-stage LD/ST hold dmem_req until dmem_ready, freezing the pipe; BEQZ/JR flush two slots.
module pipe_core #(
  parameter int              DATA_W   = 16,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              retire,
  output logic [3:0]        flags,
  output logic              halted
);
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR = 4'h4,
                         OP_XOR = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7, OP_ADDI = 4'h8,
                         OP_LD = 4'h9, OP_ST = 4'hA, OP_BEQZ = 4'hB, OP_JR = 4'hC,
                         OP_HALT = 4'hF;

  logic [PC_W-1:0]   pc_q, pc_d, ir_pc_q, ir_pc_d, x_pc_q, x_pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              ir_vld_q, ir_vld_d, x_vld_q, x_vld_d, halted_q, halted_d;
  logic [3:0]        x_op_q, x_op_d, flags_q, flags_d;
  logic [2:0]        x_rd_q, x_rd_d;
  logic [5:0]        x_imm_q, x_imm_d;
  logic [DATA_W-1:0] x_a_q, x_a_d, x_b_q, x_b_d, x_c_q, x_c_d;
  logic [DATA_W-1:0] rf_q [8];

  logic signed [5:0] imm6;
  logic [DATA_W-1:0] imm_dw, op_b, alu_res, wb_data;
  logic [PC_W-1:0]   imm_pc, target;
  logic [DATA_W:0]   sum, diff;
  logic              alu_c, alu_v, alu_op, is_ld, is_st, mem_op, stall;
  logic              wb_en, taken, do_halt;
  logic [2:0]        d_rd, d_rs0, d_rs1;

  // ---------------- execute ----------------
  assign imm6   = x_imm_q;
  assign imm_dw = DATA_W'(imm6);
  assign imm_pc = PC_W'(imm6);
  assign op_b   = (x_op_q == OP_ADDI) ? imm_dw : x_b_q;
  assign sum    = {1'b0, x_a_q} + {1'b0, op_b};
  assign diff   = {1'b0, x_a_q} - {1'b0, x_b_q};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (x_op_q)
      OP_ADD, OP_ADDI: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (x_a_q[DATA_W-1] == op_b[DATA_W-1]) && (alu_res[DATA_W-1] != x_a_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff[DATA_W-1:0];
        alu_c   = ~diff[DATA_W];  // no borrow means rs0 >= rs1 unsigned
        alu_v   = (x_a_q[DATA_W-1] != x_b_q[DATA_W-1]) && (alu_res[DATA_W-1] != x_a_q[DATA_W-1]);
      end
      OP_AND:  alu_res = x_a_q & x_b_q;
      OP_OR:   alu_res = x_a_q | x_b_q;
      OP_XOR:  alu_res = x_a_q ^ x_b_q;
      OP_SHL:  alu_res = x_a_q << x_b_q[SH_W-1:0];
      OP_SHR:  alu_res = x_a_q >> x_b_q[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  assign alu_op  = (x_op_q >= OP_ADD) && (x_op_q <= OP_ADDI);
  assign is_ld   = (x_op_q == OP_LD);
  assign is_st   = (x_op_q == OP_ST);
  assign mem_op  = x_vld_q && (is_ld || is_st);
  assign stall   = mem_op && !dmem_ready;
  assign wb_en   = x_vld_q && (x_rd_q != 3'd0) && (alu_op || (is_ld && dmem_ready));
  assign wb_data = is_ld ? dmem_rdata : alu_res;
  assign taken   = x_vld_q && (((x_op_q == OP_BEQZ) && (x_c_q == '0)) || (x_op_q == OP_JR));
  assign target  = (x_op_q == OP_JR) ? PC_W'(x_a_q) : x_pc_q + PC_W'(1) + imm_pc;
  assign do_halt = x_vld_q && (x_op_q == OP_HALT);

  assign imem_addr  = pc_q;
  assign dmem_req   = mem_op;
  assign dmem_we    = mem_op && is_st;
  assign dmem_addr  = x_a_q + imm_dw;
  assign dmem_wdata = x_c_q;
  assign retire     = x_vld_q && !stall;
  assign flags      = flags_q;
  assign halted     = halted_q;

  // ---------------- decode / next state ----------------
  assign d_rd  = ir_q[11:9];
  assign d_rs0 = ir_q[8:6];
  assign d_rs1 = ir_q[5:3];

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    ir_vld_d = ir_vld_q;
    ir_pc_d  = ir_pc_q;
    x_vld_d  = x_vld_q;
    x_op_d   = x_op_q;
    x_rd_d   = x_rd_q;
    x_imm_d  = x_imm_q;
    x_pc_d   = x_pc_q;
    x_a_d    = x_a_q;
    x_b_d    = x_b_q;
    x_c_d    = x_c_q;
    halted_d = halted_q;
    flags_d  = flags_q;
    if (x_vld_q && alu_op)
      flags_d = {alu_res == '0, alu_res[DATA_W-1], alu_c, alu_v};
    if (!halted_q) begin
      if (do_halt) begin
        halted_d = 1'b1;
        ir_vld_d = 1'b0;
        x_vld_d  = 1'b0;
      end else if (taken) begin
        pc_d     = target;
        ir_vld_d = 1'b0;
        x_vld_d  = 1'b0;
      end else if (!stall) begin
        pc_d     = pc_q + PC_W'(1);
        ir_d     = imem_data;
        ir_vld_d = 1'b1;
        ir_pc_d  = pc_q;
        x_vld_d  = ir_vld_q;
        x_op_d   = ir_q[15:12];
        x_rd_d   = d_rd;
        x_imm_d  = ir_q[5:0];
        x_pc_d   = ir_pc_q;
        // r0 is never written, so a match on index 0 cannot occur while wb_en is set
        x_a_d    = (wb_en && x_rd_q == d_rs0) ? wb_data : rf_q[d_rs0];
        x_b_d    = (wb_en && x_rd_q == d_rs1) ? wb_data : rf_q[d_rs1];
        x_c_d    = (wb_en && x_rd_q == d_rd)  ? wb_data : rf_q[d_rd];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      ir_vld_q <= 1'b0;
      ir_pc_q  <= '0;
      x_vld_q  <= 1'b0;
      x_op_q   <= '0;
      x_rd_q   <= '0;
      x_imm_q  <= '0;
      x_pc_q   <= '0;
      x_a_q    <= '0;
      x_b_q    <= '0;
      x_c_q    <= '0;
      halted_q <= 1'b0;
      flags_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ir_vld_q <= ir_vld_d;
      ir_pc_q  <= ir_pc_d;
      x_vld_q  <= x_vld_d;
      x_op_q   <= x_op_d;
      x_rd_q   <= x_rd_d;
      x_imm_q  <= x_imm_d;
      x_pc_q   <= x_pc_d;
      x_a_q    <= x_a_d;
      x_b_q    <= x_b_d;
      x_c_q    <= x_c_d;
      halted_q <= halted_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[x_rd_q] <= wb_data;
    end
  end
endmodule

// File: tb/tb_pipe_core.sv
// Directed bench: a 16-bit core runs pipeline/bypass/branch/stall/halt/reset programs,
// a 32-bit core checks wide-datapath flags; results observed through stores, retire and flags.
module tb_pipe_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        reset16 = 1'b0, ready16 = 1'b1;
  logic [15:0] imem_addr16, imem_data16, dmem_addr16, dmem_wdata16, dmem_rdata16;
  logic        dmem_req16, dmem_we16, retire16, halted16;
  logic [3:0]  flags16;
  logic [15:0] rom16 [64];
  logic [15:0] mem16 [64];

  // 32-bit instance
  logic        reset32 = 1'b0;
  logic        ready32 = 1'b1;
  logic [15:0] imem_addr32, imem_data32;
  logic [31:0] dmem_addr32, dmem_wdata32;
  logic [31:0] dmem_rdata32 = '0;
  logic        dmem_req32, dmem_we32, retire32, halted32;
  logic [3:0]  flags32;
  logic [15:0] rom32 [64];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  assign imem_data16  = rom16[imem_addr16[5:0]];
  assign dmem_rdata16 = mem16[dmem_addr16[5:0]];
  assign imem_data32  = rom32[imem_addr32[5:0]];

  always @(posedge clk)
    if (dmem_req16 && ready16 && dmem_we16) mem16[dmem_addr16[5:0]] <= dmem_wdata16;

  pipe_core u16 (
    .clk(clk), .reset(reset16), .imem_addr(imem_addr16), .imem_data(imem_data16),
    .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16),
    .dmem_wdata(dmem_wdata16), .dmem_rdata(dmem_rdata16), .dmem_ready(ready16),
    .retire(retire16), .flags(flags16), .halted(halted16)
  );

  pipe_core #(.DATA_W(32)) u32 (
    .clk(clk), .reset(reset32), .imem_addr(imem_addr32), .imem_data(imem_data32),
    .dmem_req(dmem_req32), .dmem_we(dmem_we32), .dmem_addr(dmem_addr32),
    .dmem_wdata(dmem_wdata32), .dmem_rdata(dmem_rdata32), .dmem_ready(ready32),
    .retire(retire32), .flags(flags32), .halted(halted32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle, drive dmem_ready for the new cycle, then sample mid-cycle.
  task automatic tick(input logic rdy);
    @(posedge clk);
    #2;
    ready16 = rdy;
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom16[i] = 16'h0000;
      rom32[i] = 16'h0000;
    end
    rom16[0]  = 16'h8205;  // ADDI r1,r0,5
    rom16[1]  = 16'h843D;  // ADDI r2,r0,-3
    rom16[2]  = 16'h1650;  // ADD  r3,r1,r2
    rom16[3]  = 16'hA610;  // ST   r3,[r0+0x10]
    rom16[4]  = 16'h2848;  // SUB  r4,r1,r1
    rom16[5]  = 16'hB802;  // BEQZ r4,+2
    rom16[6]  = 16'hA221;  // ST   r1,[0x21]  (skipped)
    rom16[7]  = 16'hA222;  // ST   r1,[0x22]  (skipped)
    rom16[8]  = 16'hA212;  // ST   r1,[0x12]
    rom16[9]  = 16'hA210;  // ST   r1,[0x10]  (stalled)
    rom16[10] = 16'h9A10;  // LD   r5,[0x10]
    rom16[11] = 16'h1D68;  // ADD  r6,r5,r5
    rom16[12] = 16'hAC11;  // ST   r6,[0x11]
    rom16[13] = 16'h8E3F;  // ADDI r7,r0,-1
    rom16[14] = 16'hC1C0;  // JR   r7
    rom16[15] = 16'hA221;  // skipped
    rom16[16] = 16'hA222;  // skipped
    rom16[63] = 16'hF000;  // HALT at 0xFFFF

    rom32[0] = 16'h823F;   // ADDI r1,r0,-1
    rom32[1] = 16'h1448;   // ADD  r2,r1,r1
    rom32[2] = 16'hA408;   // ST   r2,[0x8]
    rom32[3] = 16'h8801;   // ADDI r4,r0,1
    rom32[4] = 16'h7660;   // SHR  r3,r1,r4
    rom32[5] = 16'h1AE0;   // ADD  r5,r3,r4
    rom32[6] = 16'hAA09;   // ST   r5,[0x9]
    rom32[7] = 16'h5D48;   // XOR  r6,r5,r1
    rom32[8] = 16'hAC0A;   // ST   r6,[0xA]

    repeat (3) @(negedge clk);
    check("rst_retire", 32'(retire16), 0);
    check("rst_req",    32'(dmem_req16), 0);
    check("rst_we",     32'(dmem_we16), 0);
    check("rst_halted", 32'(halted16), 0);
    check("rst_flags",  32'(flags16), 0);
    check("rst_pc",     32'(imem_addr16), 0);

    @(posedge clk); #2; reset16 = 1'b1; #1; cyc = 0;
    check("c0_pc", 32'(imem_addr16), 0);
    check("c0_retire", 32'(retire16), 0);
    tick(1); check("c1_retire", 32'(retire16), 0);
    tick(1); check("c2_retire", 32'(retire16), 1);
    tick(1); check("c3_flags_addi5", 32'(flags16), 'b0000);
    tick(1); check("c4_add_retire", 32'(retire16), 1);
    check("c4_flags_addim3", 32'(flags16), 'b0100);
    tick(1); check("c5_flags_add", 32'(flags16), 'b0010);
    check("c5_st_req", 32'(dmem_req16), 1);
    check("c5_st_we", 32'(dmem_we16), 1);
    check("c5_st_addr", 32'(dmem_addr16), 'h10);
    check("c5_st_wdata_r3", 32'(dmem_wdata16), 2);

    tick(1); check("c6_sub_retire", 32'(retire16), 1);
    tick(1); check("c7_beqz_retire", 32'(retire16), 1);
    check("c7_flags_sub", 32'(flags16), 'b1010);
    tick(1); check("c8_bubble", 32'(retire16), 0);
    check("c8_pc_target", 32'(imem_addr16), 8);
    check("c8_no_req", 32'(dmem_req16), 0);
    tick(1); check("c9_bubble", 32'(retire16), 0);
    check("c9_no_req", 32'(dmem_req16), 0);
    tick(1); check("c10_target_retire", 32'(retire16), 1);
    check("c10_st_addr", 32'(dmem_addr16), 'h12);
    check("c10_st_wdata", 32'(dmem_wdata16), 5);

    for (int k = 11; k <= 14; k++) begin
      tick(k == 14);
      check("stall_req", 32'(dmem_req16), 1);
      check("stall_we", 32'(dmem_we16), 1);
      check("stall_addr", 32'(dmem_addr16), 'h10);
      check("stall_wdata", 32'(dmem_wdata16), 5);
      check("stall_pc", 32'(imem_addr16), 11);
      check("stall_retire", 32'(retire16), (k == 14) ? 1 : 0);
    end
    tick(1); check("c15_ld_req", 32'(dmem_req16), 1);
    check("c15_ld_we", 32'(dmem_we16), 0);
    check("c15_ld_addr", 32'(dmem_addr16), 'h10);
    check("c15_pc", 32'(imem_addr16), 12);
    check("c15_retire", 32'(retire16), 1);
    tick(1); check("c16_add_noreq", 32'(dmem_req16), 0);
    check("c16_flags_keep", 32'(flags16), 'b1010);
    tick(1); check("c17_st_addr", 32'(dmem_addr16), 'h11);
    check("c17_st_r6", 32'(dmem_wdata16), 10);
    check("c17_flags_add", 32'(flags16), 'b0000);
    check("mem_0x10", 32'(mem16[16]), 5);

    tick(1); tick(1);
    check("c19_jr_retire", 32'(retire16), 1);
    check("c19_flags_addi", 32'(flags16), 'b0100);
    tick(1); check("c20_pc_ffff", 32'(imem_addr16), 'hFFFF);
    check("c20_no_req", 32'(dmem_req16), 0);
    tick(1); check("c21_pc_wrap", 32'(imem_addr16), 0);
    check("c21_no_req", 32'(dmem_req16), 0);
    tick(1); check("c22_halt_retire", 32'(retire16), 1);
    check("c22_not_halted", 32'(halted16), 0);
    for (int k = 23; k <= 30; k++) begin
      tick(1);
      check("halt_halted", 32'(halted16), 1);
      check("halt_retire", 32'(retire16), 0);
      check("halt_req", 32'(dmem_req16), 0);
    end

    // Reset while halted, then reset in the middle of a stalled load
    rom16[0] = 16'h9210;  // LD r1,[r0+0x10]
    reset16 = 1'b0; #1;
    check("rst_halt_clear", 32'(halted16), 0);
    check("rst_halt_pc", 32'(imem_addr16), 0);
    @(posedge clk); #2; reset16 = 1'b1; ready16 = 1'b0; #1; cyc = 0;
    check("r2c0_pc", 32'(imem_addr16), 0);
    tick(0); tick(0);
    check("ld_req", 32'(dmem_req16), 1);
    check("ld_we", 32'(dmem_we16), 0);
    check("ld_addr", 32'(dmem_addr16), 'h10);
    check("ld_stall_retire", 32'(retire16), 0);
    tick(0); check("ld_stall_pc", 32'(imem_addr16), 2);
    reset16 = 1'b0; #1;
    check("midld_req", 32'(dmem_req16), 0);
    check("midld_retire", 32'(retire16), 0);
    check("midld_pc", 32'(imem_addr16), 0);
    check("midld_halted", 32'(halted16), 0);
    @(posedge clk); #2; reset16 = 1'b1; ready16 = 1'b1; #1; cyc = 0;
    check("r3c0_pc", 32'(imem_addr16), 0);
    tick(1); check("r3c1_pc", 32'(imem_addr16), 1);
    tick(1); check("r3c2_ld_retire", 32'(retire16), 1);

    // 32-bit datapath
    check("w_rst_flags", 32'(flags32), 0);
    check("w_rst_req", 32'(dmem_req32), 0);
    @(posedge clk); #2; reset32 = 1'b1; #1; cyc = 0;
    tick(1); tick(1); tick(1);
    check("w_c3_flags_addi", 32'(flags32), 'b0100);
    tick(1); check("w_c4_flags_add", 32'(flags32), 'b0110);
    check("w_c4_st_addr", dmem_addr32, 'h8);
    check("w_c4_st_wdata", dmem_wdata32, 'hFFFF_FFFE);
    check("w_c4_st_we", 32'(dmem_we32), 1);
    tick(1); tick(1); check("w_c6_flags_addi1", 32'(flags32), 'b0000);
    tick(1); check("w_c7_flags_shr", 32'(flags32), 'b0000);
    tick(1); check("w_c8_flags_ovf", 32'(flags32), 'b0101);
    check("w_c8_st_wdata", dmem_wdata32, 'h8000_0000);
    tick(1); check("w_c9_flags_keep", 32'(flags32), 'b0101);
    tick(1); check("w_c10_flags_xor", 32'(flags32), 'b0000);
    check("w_c10_st_wdata", dmem_wdata32, 'h7FFF_FFFF);
    check("w_halted", 32'(halted32), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_core.md
# pipe_core

Parametrised three-stage (fetch / decode / execute) processor core, the pipelined successor to the single-issue 16-bit datapath. It generalises data and PC width, adds a ready/valid data-memory handshake, operand bypassing, branch flushing and a halt state. The core sits between an external instruction ROM (combinational read) and a data RAM, with an observable retire strobe and flag register.

## Interface
- DATA_W, 16: register, ALU and data-memory width (≥8).
- PC_W, 16: program counter / instruction address width.
- RESET_PC, 0: first fetch address after reset.

- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- imem_addr  out  PC_W  fetch address (= PC).
- imem_data  in  16  instruction at imem_addr, valid same cycle.
- dmem_req  out  1  data access request, held until accepted.
- dmem_we  out  1  1 = store, 0 = load; stable while dmem_req.
- dmem_addr  out  DATA_W  byte-agnostic word address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready.
- dmem_ready  in  1  access completes this cycle (may be same cycle as first req).
- retire  out  1  an instruction completes execute this cycle.
- flags  out  4  {Z,N,C,V}.
- halted  out  1  core stopped by HALT.

## Operation
- Format: [15:12] op, [11:9] rd, [8:6] rs0, [5:3] rs1, imm = sext(inst[5:0]) to DATA_W. 8 registers; r0 reads 0, writes discarded.
- Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR (rd = rs0 op rs1); 6 SHL, 7 SHR logical (amount = rs1[clog2(DATA_W)-1:0]); 8 ADDI rd = rs0+imm; 9 LD rd = mem[rs0+imm]; A ST mem[rs0+imm] = rd; B BEQZ if rd==0 PC = bpc+1+imm (bpc = branch's own PC, PC_W wrap); C JR PC = rs0[PC_W-1:0]; D, E reserved = NOP; F HALT.
- Arithmetic modulo 2^DATA_W. Flags updated only by ops 1–8: Z = result==0, N = result MSB; C = carry-out (ADD/ADDI), borrow-free = 1 when rs0 ≥ rs1 unsigned (SUB), 0 for logic/shift; V = signed overflow for ADD/ADDI/SUB, 0 otherwise.
- Fetch: IR ← imem_data, PC ← PC+1 (wraps). Decode: read rs0/rs1/rd, capture into X latch with bpc. Execute: ALU/address, memory, branch resolve, register writeback at end of cycle.
- Bypass: when X writes rd this cycle and D reads the same nonzero register, D captures the X write data (ALU result or dmem_rdata). No load-use stall.
- Stall: X holding LD/ST with dmem_ready=0 freezes PC, IR and X latch; dmem_req stays high, address/data stable.
- Taken BEQZ / JR: PC ← target, IR and D contents invalidated (2 bubbles).
- HALT in X: halted ← 1, retire pulses once, younger instructions discarded, no further fetch/writeback/dmem_req until reset.

## Timing
- Reset values: PC = RESET_PC, IR/X valid = 0, registers = 0, flags = 0, halted = 0, retire = 0, dmem_req = 0, dmem_we = 0.
- Latency: instruction fetched in cycle n retires (retire high) in cycle n+2 without stalls; writeback at the end of that cycle.
- Throughput: 1 instruction/cycle absent stalls/branches.
- dmem_req asserted only in cycles where X holds valid LD/ST; deasserts the cycle after acceptance unless the next X op is also memory.
- Reset asserted mid-stall or mid-access: request dropped immediately; no write assumed.
- Simultaneous taken branch and stall cannot occur (branches never stall).

## Test plan
- Reset, ROM: ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 -> r3 = 2 retires in cycle 4, flags Z=0,N=0,C=1,V=0, no stalls (bypass used).
- SUB r4,r1,r1 then BEQZ r4,+2 -> next two sequential instructions never retire, target retires 3 cycles after branch retire; retire gap of 2 cycles.
- ST r1 to addr 0x10 with dmem_ready low 3 cycles, then LD r5 from 0x10 and ADD r6,r5,r5 -> dmem_req held 4 cycles with stable addr/wdata, r6 = 10, PC frozen during stall.
- DATA_W=32: ADDI r1,r0,-1; ADD r2,r1,r1 -> r2 = 0xFFFFFFFE, C=1, N=1; ADD 0x7FFFFFFF+1 -> V=1.
- JR to PC (2^PC_W)-1 then sequential -> PC wraps to 0; HALT -> halted=1, no retire or dmem_req afterward; assert reset mid-load -> dmem_req low at once, halted = 0, fetch resumes at RESET_PC.
